// File: rtl/cad_pkg.sv
// Shared constants, state/error encodings and word-count lookup for the CAD
// result-stream deserializer.
package cad_pkg;

  localparam int WORD_W = 20;
  localparam int CNT_W  = 11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_RECV  = 2'd2;
  localparam state_t ST_ERR   = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_GAP     = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_SIZE    = 2'd3
  } err_code_e;

  localparam logic [1:0] SZ_8   = 2'd0;
  localparam logic [1:0] SZ_16  = 2'd1;
  localparam logic [1:0] SZ_32  = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  // mode 0: ((n-4)/2)^2 after conv + 2x2 pool; mode 1: (n+4)^2 after deconv
  function automatic logic [CNT_W-1:0] exp_words(input logic mode, input logic [1:0] size);
    logic [CNT_W-1:0] n;
    n = '0;
    case ({mode, size})
      {1'b0, SZ_8}:  n = CNT_W'(4);
      {1'b0, SZ_16}: n = CNT_W'(36);
      {1'b0, SZ_32}: n = CNT_W'(196);
      {1'b1, SZ_8}:  n = CNT_W'(144);
      {1'b1, SZ_16}: n = CNT_W'(400);
      {1'b1, SZ_32}: n = CNT_W'(1296);
      default:       n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cad_word_shifter.sv
// LSB-first word assembler: collects WORD_W serial bits and strobes full on
// the cycle the last bit is presented, with the complete word alongside.
module cad_word_shifter
  import cad_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic              full,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-2:0] sh;
  logic [4:0]        bit_cnt;

  // The final bit is never stored; it is merged straight into the output word.
  assign full = en && (bit_cnt == 5'(WORD_W - 1));
  assign word = {bit_in, sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      sh      <= {bit_in, sh[WORD_W-2:1]};
      bit_cnt <= full ? 5'd0 : bit_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/cad_out_deser.sv
// CAD result-stream deserializer: reassembles 20-bit words from the serial
// out_value pin, counts them against the armed pattern size and flags errors.
module cad_out_deser
  import cad_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              mode,
  input  logic [1:0]        matrix_size,
  input  logic              out_valid,
  input  logic              out_value,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [CNT_W-1:0]  word_idx,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  // state    | meaning
  // IDLE     | waiting for arm; out_valid here is an overrun
  // ARMED    | size latched, waiting for first out_valid
  // RECV     | shifting bits in, emitting words
  // ERR      | protocol error seen, waiting for arm

  state_t            state;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  n_exp;
  logic              sh_clr;
  logic              sh_en;
  logic              sh_full;
  logic [WORD_W-1:0] sh_word;

  assign sh_en  = !arm && out_valid && (state == ST_ARMED || state == ST_RECV);
  assign sh_clr = arm || (state == ST_RECV && !out_valid);

  cad_word_shifter u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (sh_clr),
    .en     (sh_en),
    .bit_in (out_value),
    .full   (sh_full),
    .word   (sh_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      n_exp      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_idx   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      word_valid <= 1'b0;
      done       <= 1'b0;
      if (arm) begin
        n_exp    <= exp_words(mode, matrix_size);
        word_cnt <= '0;
        if (matrix_size == SZ_RSV) begin
          state    <= ST_ERR;
          err      <= 1'b1;
          err_code <= ERR_SIZE;
        end else begin
          state    <= ST_ARMED;
          err      <= 1'b0;
          err_code <= ERR_NONE;
        end
      end else begin
        case (state)
          ST_ARMED: begin
            if (out_valid) state <= ST_RECV;
          end
          ST_RECV: begin
            if (!out_valid) begin
              state <= ST_ERR;
              err   <= 1'b1;
              if (!err) err_code <= ERR_GAP;
            end else if (sh_full) begin
              word_valid <= 1'b1;
              word_data  <= sh_word;
              word_idx   <= word_cnt;
              if (word_cnt == n_exp - CNT_W'(1)) begin
                done     <= 1'b1;
                word_cnt <= '0;
                state    <= ST_IDLE;
              end else begin
                word_cnt <= word_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            // IDLE and ERR: stray data is an overrun, state is left alone
            if (out_valid) begin
              err <= 1'b1;
              if (!err) err_code <= ERR_OVERRUN;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cad_out_deser.sv
// Directed bench for cad_out_deser: streams hand-built patterns and checks
// emitted words, done, and error reporting.
module tb_cad_out_deser;
  import cad_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              mode = 1'b0;
  logic [1:0]        matrix_size = 2'd0;
  logic              out_valid = 1'b0;
  logic              out_value = 1'b0;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [CNT_W-1:0]  word_idx;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WORD_W-1:0] wq_data[$];
  logic [CNT_W-1:0]  wq_idx[$];
  int                wq_cyc[$];
  int                done_cnt  = 0;
  int                done_idx  = -1;
  int                done_nowv = 0;

  cad_out_deser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .mode        (mode),
    .matrix_size (matrix_size),
    .out_valid   (out_valid),
    .out_value   (out_value),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_idx    (word_idx),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (word_valid) begin
      wq_data.push_back(word_data);
      wq_idx.push_back(word_idx);
      wq_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_idx = int'(word_idx);
      if (!word_valid) done_nowv++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq_data.delete();
    wq_idx.delete();
    wq_cyc.delete();
    done_cnt  = 0;
    done_idx  = -1;
    done_nowv = 0;
  endtask

  // All stimulus tasks start and end at a falling edge.
  task automatic do_arm(input logic m, input logic [1:0] s, input logic ov);
    arm = 1'b1; mode = m; matrix_size = s; out_valid = ov; out_value = 1'b0;
    @(negedge clk);
    arm = 1'b0; out_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [WORD_W-1:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      out_valid = 1'b1;
      out_value = w[i];
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    out_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [WORD_W-1:0] pat5(input int k);
    return WORD_W'(k * 1234 + 5);
  endfunction

  logic [WORD_W-1:0] t1_words[4];
  int                nbad;
  int                ngap;
  logic [WORD_W-1:0] lastd;
  logic [CNT_W-1:0]  lasti;

  initial begin
    t1_words[0] = 20'h00001;
    t1_words[1] = 20'hFFFFF;
    t1_words[2] = 20'h80000;
    t1_words[3] = 20'h12345;

    #12;
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
    chk("rst_word_data",  32'(word_data),  32'd0);
    chk("rst_word_idx",   32'(word_idx),   32'd0);
    chk("rst_err_code",   32'(err_code),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // mode 0, 8x8: four words back-to-back
    clear_log();
    do_arm(1'b0, SZ_8, 1'b0);
    for (int k = 0; k < 4; k++) send_bits(t1_words[k], 20);
    idle(3);
    chk("t1_count", 32'(wq_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_data%0d", k), (k < wq_data.size()) ? 32'(wq_data[k]) : 32'hDEAD, 32'(t1_words[k]));
      chk($sformatf("t1_idx%0d", k),  (k < wq_idx.size())  ? 32'(wq_idx[k])  : 32'hDEAD, 32'(k));
    end
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_idx", 32'(done_idx), 32'd3);
    chk("t1_done_wv",  32'(done_nowv), 32'd0);
    chk("t1_err",      32'(err), 32'd0);

    // mode 1, 32x32: 1296 words, word k = k
    clear_log();
    do_arm(1'b1, SZ_32, 1'b0);
    for (int k = 0; k < 1296; k++) send_bits(WORD_W'(k), 20);
    idle(3);
    nbad = 0;
    ngap = 0;
    for (int i = 0; i < wq_data.size(); i++) begin
      if (wq_data[i] != WORD_W'(i) || wq_idx[i] != CNT_W'(i)) nbad++;
      if (i > 0 && (wq_cyc[i] - wq_cyc[i-1]) != 20) ngap++;
    end
    lastd = (wq_data.size() > 0) ? wq_data[$] : '1;
    lasti = (wq_idx.size() > 0)  ? wq_idx[$]  : '1;
    chk("t2_count",     32'(wq_data.size()), 32'd1296);
    chk("t2_last_idx",  32'(lasti), 32'd1295);
    chk("t2_last_data", 32'(lastd), 32'h0050F);
    chk("t2_bad_words", 32'(nbad), 32'd0);
    chk("t2_spacing",   32'(ngap), 32'd0);
    chk("t2_done_cnt",  32'(done_cnt), 32'd1);
    chk("t2_done_idx",  32'(done_idx), 32'd1295);
    chk("t2_err",       32'(err), 32'd0);

    // mode 0, 16x16: out_valid drops after 37 bits
    clear_log();
    do_arm(1'b0, SZ_16, 1'b0);
    send_bits(20'hABCDE, 20);
    send_bits(20'h1FFFF, 17);
    idle(3);
    chk("t3_err",      32'(err), 32'd1);
    chk("t3_err_code", 32'(err_code), 32'(ERR_GAP));
    chk("t3_count",    32'(wq_data.size()), 32'd1);
    chk("t3_data",     (wq_data.size() > 0) ? 32'(wq_data[0]) : 32'hDEAD, 32'hABCDE);
    chk("t3_done_cnt", 32'(done_cnt), 32'd0);
    do_arm(1'b0, SZ_16, 1'b0);
    chk("t3_arm_err",  32'(err), 32'd0);
    chk("t3_arm_code", 32'(err_code), 32'd0);

    // overrun in IDLE after reset, then reserved size
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    send_bits(20'h00001, 1);
    idle(1);
    chk("t4_err",      32'(err), 32'd1);
    chk("t4_err_code", 32'(err_code), 32'(ERR_OVERRUN));
    chk("t4_state",    32'(dut.state), 32'(ST_IDLE));
    do_arm(1'b0, SZ_RSV, 1'b0);
    chk("t4_size_err",  32'(err), 32'd1);
    chk("t4_size_code", 32'(err_code), 32'(ERR_SIZE));
    chk("t4_size_st",   32'(dut.state), 32'(ST_ERR));
    send_bits(20'h00001, 2);
    idle(1);
    chk("t4_first_kept", 32'(err_code), 32'(ERR_SIZE));

    // mode 0, 32x32: re-arm at bit 10 of word 2, then full restart
    clear_log();
    do_arm(1'b0, SZ_32, 1'b0);
    send_bits(pat5(0), 20);
    send_bits(pat5(1), 20);
    send_bits(pat5(2), 10);
    do_arm(1'b0, SZ_32, 1'b1);
    chk("t5_pre_count", 32'(wq_data.size()), 32'd2);
    chk("t5_pre_done",  32'(done_cnt), 32'd0);
    clear_log();
    for (int k = 0; k < 196; k++) send_bits(pat5(k), 20);
    idle(3);
    nbad = 0;
    for (int i = 0; i < wq_data.size(); i++)
      if (wq_data[i] != pat5(i) || wq_idx[i] != CNT_W'(i)) nbad++;
    chk("t5_count",    32'(wq_data.size()), 32'd196);
    chk("t5_first",    (wq_data.size() > 0) ? 32'(wq_data[0]) : 32'hDEAD, 32'(pat5(0)));
    chk("t5_first_i",  (wq_idx.size() > 0)  ? 32'(wq_idx[0])  : 32'hDEAD, 32'd0);
    chk("t5_bad",      32'(nbad), 32'd0);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_done_idx", 32'(done_idx), 32'd195);

    // async reset mid-word
    do_arm(1'b0, SZ_8, 1'b0);
    send_bits(20'h0001F, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", 32'(word_data), 32'd0);
    chk("t6_rst_idx",  32'(word_idx),  32'd0);
    chk("t6_rst_wv",   32'(word_valid), 32'd0);
    chk("t6_rst_err",  32'(err), 32'd0);
    rst_n = 1'b1;
    clear_log();
    send_bits(20'hFFFFF, 20);
    idle(2);
    chk("t6_no_words", 32'(wq_data.size()), 32'd0);
    chk("t6_overrun",  32'(err_code), 32'(ERR_OVERRUN));
    do_arm(1'b0, SZ_8, 1'b0);
    for (int k = 0; k < 4; k++) send_bits(t1_words[k], 20);
    idle(3);
    chk("t6_rearm_cnt",  32'(wq_data.size()), 32'd4);
    chk("t6_rearm_done", 32'(done_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cad_out_deser.md
# cad_out_deser

Receive-side deserializer for the CAD result stream: it samples the 1-bit serial `out_value` while `out_valid` is high and reassembles 20-bit result words, LSB first. It knows the expected word count from the `mode`/`matrix_size` of the current pattern and flags protocol violations. It sits between the CAD output pins and the on-chip result checker/scoreboard logic.

## Interface
- `WORD_W`, 20: bits per result word.
- `CNT_W`, 11: word-counter width; must hold 1296.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `arm` input 1: one-cycle pulse; starts a new pattern and captures `mode` and `matrix_size`.
- `mode` input 1: 0 = convolution + 2x2 max-pool; 1 = transposed convolution (deconvolution).
- `matrix_size` input 2: 0 = 8x8, 1 = 16x16, 2 = 32x32, 3 = reserved.
- `out_valid` input 1: CAD serial-valid.
- `out_value` input 1: CAD serial data bit.
- `word_valid` output 1: one-cycle strobe; `word_data` and `word_idx` are valid.
- `word_data` output WORD_W: assembled word.
- `word_idx` output CNT_W: index of that word, 0-based, in raster order.
- `done` output 1: one-cycle pulse after the last expected word.
- `err` output 1: sticky error flag; cleared by `arm` or reset.
- `err_code` output 2: 0 none, 1 gap (out_valid fell mid-stream), 2 overrun (out_valid while not RECV), 3 bad size.

## Operation
- Expected word count N is latched on `arm`.
  - mode 0: ((n-4)/2)^2 → 4 / 36 / 196 for n = 8 / 16 / 32.
  - mode 1: (n+4)^2 → 144 / 400 / 1296.
- FSM states: IDLE, ARMED, RECV, ERR.
  - IDLE → ARMED on `arm`.
  - If `matrix_size`==3 on `arm`: go to ERR, code 3.
  - ARMED → RECV on the first `out_valid`=1. That cycle's bit is bit 0 of word 0.
  - RECV: shift `out_value` into bit position `bit_cnt`; `bit_cnt` counts 0..19 and wraps.
    - On `bit_cnt`==19, emit the word and increment `word_cnt`.
    - When `word_cnt` reaches N-1 and its 20th bit arrives: emit the word, pulse `done`, return to IDLE.
  - RECV with `out_valid`=0 before completion: ERR, code 1. Any partial word is discarded.
  - `out_valid`=1 in IDLE or ERR: `err`=1, code 2. State is unchanged.
  - ERR → ARMED on `arm`.
- `arm` has priority over every other event in every state, including mid-RECV. It restarts the pattern, zeroes the counters and clears `err`.
- Only the first error's code is kept until cleared.

## Timing
- Reset values:
  - FSM = IDLE.
  - All counters = 0.
  - `word_valid`, `done`, `err` = 0.
  - `word_data` = 0, `word_idx` = 0, `err_code` = 0.
- Latency: `word_valid` asserts on the clock edge after the edge that samples bit 19, so it is visible 1 cycle after the last bit.
- `word_data`/`word_idx` hold their values until the next `word_valid`.
- `done` asserts in the same cycle as the final `word_valid`.
- Throughput: back-to-back words, one per 20 cycles, with no bubble required between words.
- Counter wrap: `word_cnt` never exceeds N-1. `bit_cnt` wraps 19→0 in the same cycle a word is emitted.
- `arm` coinciding with the final bit: `arm` wins. No `word_valid` and no `done`; the FSM goes to ARMED.
- `arm` coinciding with `out_valid` in IDLE: no overrun error. The FSM goes to ARMED, and that bit is not sampled.
- Asynchronous reset mid-stream: all outputs return to reset values immediately. Subsequent `out_valid` raises overrun until the next `arm`.

## Structure
- Shared package `cad_pkg`:
  - `WORD_W`.
  - FSM state enum.
  - `err_code` enum.
  - size-encoding constants.
  - function `exp_words(mode, size)` returning N.
- Sub-module `cad_word_shifter`:
  - 20-bit LSB-first shift/assemble register with bit counter.
  - Outputs a `full` strobe.
  - The FSM and word counter stay in the top.

## Test plan
- mode 0, size 0, stream 4 words 0x00001, 0xFFFFF, 0x80000, 0x12345 (80 contiguous cycles) → 4 `word_valid` with exact values and idx 0..3; `done` with idx 3; `err`=0.
- mode 1, size 2, 1296 words where word k = k → last `word_idx`=1295, `word_data`=0x0050F, `done` once; all words contiguous, 20 cycles apart.
- mode 0, size 1, drop `out_valid` after 37 bits → `err`=1, `err_code`=1, exactly 1 `word_valid` and no `done`; `arm` then clears `err`.
- `out_valid` pulsed in IDLE after reset → `err_code`=2, state stays IDLE; `arm` with `matrix_size`=3 → `err_code`=3.
- `arm` asserted at bit 10 of word 2 of a mode 0 size 2 stream, restart stream → word 0 re-emitted at idx 0; the total count of 196 is reached and `done` pulses.
- `rst_n` low for 1 ns mid-word → outputs 0 immediately; no `word_valid` until the next `arm` and a new stream.
